reg_counter: RTL
================

Name: reg_counter

Overview:
Parametrised successor to the 16-bit write/increment register, used as the program-counter and address register in each core. Adds:
- configurable width and step
- decrement and synchronous clear
- a configurable write-delay pipeline
- wrap and terminal-count flags

All outputs are registered or derived from registered state. Single clock domain.

Parameters:
WIDTH, 16, data/counter width in bits (2..32).
STEP, 1, increment/decrement amount; treated as a WIDTH-bit unsigned value.
WR_DELAY, 1, cycles between write request and register update (0..3). WR_DELAY=1 is compatible with the existing core timing.
RESET_VAL, 0, value loaded into data_out on reset or clear.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
reg_write_en  input  1  write request; data_in is captured in the same cycle
reg_inc_en  input  1  add STEP this cycle
reg_dec_en  input  1  subtract STEP this cycle
reg_clr_en  input  1  load RESET_VAL this cycle
data_in  input  WIDTH  write data
tc_val  input  WIDTH  terminal-count compare value
data_out  output  WIDTH  register value
wrap  output  1  one-cycle pulse: the previous update wrapped (inc overflow or dec underflow)
tc  output  1  high whenever data_out == tc_val (combinational compare of registered value)
wr_pending  output  1  high while any write is in the delay pipeline

Behaviour:
- Reset: rst is sampled on the rising edge of clk and is synchronous, active-high.
  - data_out <= RESET_VAL, wrap <= 0.
  - All delay-pipeline valid bits are cleared; writes in flight are discarded.
  - rst takes priority over every other input.
- Write pipeline:
  - For WR_DELAY=N>=1, an N-stage shift register carries {valid, data}.
  - Stage 0 loads {reg_write_en, data_in} every cycle.
  - The write is applied at the edge N cycles after issue. Example: WR_DELAY=1, issue at edge k, data_out = data_in at edge k+1.
  - WR_DELAY=0: no pipeline; the write is applied at the issue edge.
  - Back-to-back writes are all preserved and applied in order.
  - wr_pending = OR of the stage valid bits; it is 0 when WR_DELAY=0.
- Update priority per edge, highest first. Exactly one action applies.
  1. reg_clr_en: data_out <= RESET_VAL. Any write reaching the output this cycle is discarded; writes in earlier pipeline stages continue.
  2. reg_inc_en XOR reg_dec_en: data_out <= data_out ± STEP, modulo 2^WIDTH. A write reaching the output this cycle is discarded (inc over write, as in the existing register).
  3. Matured write: data_out <= captured data.
  4. Otherwise hold. inc and dec asserted together count as hold, and a matured write still applies.
- wrap:
  - Set to 1 on the edge where an inc result has an unsigned carry-out or a dec result borrows; otherwise 0 at every edge.
  - Never set by clear or write.
  - Example: WIDTH=16, STEP=1, data_out=0xFFFF, inc -> data_out=0x0000, wrap=1 for one cycle.
- tc: updates the same cycle data_out or tc_val changes; it has no latching.
- Arithmetic: computed at WIDTH+1 bits. The low WIDTH bits are stored; bit WIDTH (carry/borrow) drives wrap.

Optional Feature:
Macro REG_COUNTER_SAT_EN.
- Defined:
  - inc whose result would exceed 2^WIDTH-1 saturates at all-ones.
  - dec that would go below 0 saturates at 0.
  - wrap is then high for one cycle on any saturating inc/dec, including one already at the limit; it acts as the saturation indicator.
  - All other behaviour is unchanged.
- Undefined: modulo arithmetic as above. No saturation logic is synthesised.

Test Plan:
1. WIDTH=16, WR_DELAY=1, after rst: write 0x1234 at edge 1 -> data_out=0x0000 after edge 1, 0x1234 after edge 2; wr_pending=1 between edges 1 and 2.
2. Preload 0xFFFE, inc for 3 cycles -> data_out 0xFFFF, 0x0000, 0x0001; wrap=1 only in the cycle after 0x0000 is loaded.
3. WR_DELAY=2: writes 0x0001, 0x0002, 0x0003 on consecutive edges -> data_out shows 0x0001, 0x0002, 0x0003 starting 2 cycles later. With inc asserted at the edge 0x0002 matures -> data_out=0x0002 (0x0001+1), and 0x0003 is applied next.
4. data_out=0x0010, inc and dec together -> hold 0x0010. clr together with a matured write 0x00AA -> data_out=RESET_VAL.
5. rst asserted while 2 writes are pending (WR_DELAY=3) -> data_out=RESET_VAL, wr_pending=0, and no late update follows.
6. With REG_COUNTER_SAT_EN, STEP=4, data_out=0x0002, dec -> 0x0000 with wrap=1. Set tc_val=0x0000 -> tc=1 in the same cycle.

Source files
------------

// File: rtl/reg_counter.sv
// Parametrised PC/address register: write with configurable delay pipeline, inc/dec by STEP, clear, wrap and terminal-count flags.
// Optional saturating arithmetic is enabled with macro REG_COUNTER_SAT_EN.
module reg_counter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STEP      = 1,
  parameter int unsigned WR_DELAY  = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write_en,
  input  logic             reg_inc_en,
  input  logic             reg_dec_en,
  input  logic             reg_clr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] tc_val,
  output logic [WIDTH-1:0] data_out,
  output logic             wrap,
  output logic             tc,
  output logic             wr_pending
);

  localparam int unsigned XW = WIDTH + 1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_data;
  logic             r_wrap;
  logic             w_mat_vld;
  logic [WIDTH-1:0] w_mat_dat;
  logic [XW-1:0]    w_sum;
  logic [XW-1:0]    w_diff;
  logic [WIDTH-1:0] w_nxt_data;
  logic             w_nxt_wrap;

  generate
    if (WR_DELAY == 0) begin : g_no_dly
      assign w_mat_vld  = reg_write_en;
      assign w_mat_dat  = data_in;
      assign wr_pending = 1'b0;
    end else begin : g_dly
      logic [WR_DELAY-1:0] r_vld;
      logic [WIDTH-1:0]    r_dat [WR_DELAY];

      // Valid bits are reset so in-flight writes are discarded.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= reg_write_en;
          for (int i = 1; i < int'(WR_DELAY); i++) begin
            r_vld[i] <= r_vld[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_dat[0] <= data_in;
        for (int i = 1; i < int'(WR_DELAY); i++) begin
          r_dat[i] <= r_dat[i-1];
        end
      end

      assign w_mat_vld  = r_vld[WR_DELAY-1];
      assign w_mat_dat  = r_dat[WR_DELAY-1];
      assign wr_pending = |r_vld;
    end
  endgenerate

  // Carry/borrow lands in bit WIDTH of the extended result.
  assign w_sum  = {1'b0, r_data} + {1'b0, STEP_W};
  assign w_diff = {1'b0, r_data} - {1'b0, STEP_W};

  // Priority: clear > single inc/dec > matured write > hold.
  always_comb begin
    w_nxt_data = r_data;
    w_nxt_wrap = 1'b0;
    if (reg_clr_en) begin
      w_nxt_data = RST_W;
    end else if (reg_inc_en && !reg_dec_en) begin
      w_nxt_data = w_sum[WIDTH-1:0];
      w_nxt_wrap = w_sum[WIDTH];
`ifdef REG_COUNTER_SAT_EN
      if (w_sum[WIDTH]) w_nxt_data = '1;
`endif
    end else if (reg_dec_en && !reg_inc_en) begin
      w_nxt_data = w_diff[WIDTH-1:0];
      w_nxt_wrap = w_diff[WIDTH];
`ifdef REG_COUNTER_SAT_EN
      if (w_diff[WIDTH]) w_nxt_data = '0;
`endif
    end else if (w_mat_vld) begin
      w_nxt_data = w_mat_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= RST_W;
      r_wrap <= 1'b0;
    end else begin
      r_data <= w_nxt_data;
      r_wrap <= w_nxt_wrap;
    end
  end

  assign data_out = r_data;
  assign wrap     = r_wrap;
  assign tc       = (r_data == tc_val);

endmodule
